// File: rtl/mem_align_unit_pkg.sv
// Shared definitions for mem_align_unit: load/store op codes, FSM state codes, lane masks
// and the op decoder used by the top and the lane extractor.
package mem_align_unit_pkg;

   localparam logic [7:0] EXE_LB_OP  = 8'b0010_0000;
   localparam logic [7:0] EXE_LH_OP  = 8'b0010_0001;
   localparam logic [7:0] EXE_LW_OP  = 8'b0010_0011;
   localparam logic [7:0] EXE_LBU_OP = 8'b0010_0100;
   localparam logic [7:0] EXE_LHU_OP = 8'b0010_0101;
   localparam logic [7:0] EXE_SB_OP  = 8'b0010_1000;
   localparam logic [7:0] EXE_SH_OP  = 8'b0010_1001;
   localparam logic [7:0] EXE_SW_OP  = 8'b0010_1011;

   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_WAIT = 2'd1;
   localparam logic [1:0] ST_RESP = 2'd2;

   // Lane masks before shifting to the byte offset; wide enough for a 64-bit path.
   localparam logic [7:0] LANE_MASK_B = 8'h01;
   localparam logic [7:0] LANE_MASK_H = 8'h03;
   localparam logic [7:0] LANE_MASK_W = 8'h0f;

   typedef enum logic [1:0] {
      SZ_BYTE = 2'd0,
      SZ_HALF = 2'd1,
      SZ_WORD = 2'd2
   } size_e;

   typedef struct packed {
      logic  valid;
      logic  store;
      logic  sign;
      size_e size;
   } op_info_t;

   function automatic op_info_t decode_op(input logic [7:0] op);
      op_info_t info;
      info.valid = 1'b1;
      info.store = 1'b0;
      info.sign  = 1'b0;
      info.size  = SZ_WORD;
      case (op)
         EXE_LB_OP:  begin info.sign = 1'b1; info.size = SZ_BYTE; end
         EXE_LBU_OP: info.size = SZ_BYTE;
         EXE_LH_OP:  begin info.sign = 1'b1; info.size = SZ_HALF; end
         EXE_LHU_OP: info.size = SZ_HALF;
         EXE_LW_OP:  info.sign = 1'b1;
         EXE_SB_OP:  begin info.store = 1'b1; info.size = SZ_BYTE; end
         EXE_SH_OP:  begin info.store = 1'b1; info.size = SZ_HALF; end
         EXE_SW_OP:  info.store = 1'b1;
         default:    info.valid = 1'b0;
      endcase
      return info;
   endfunction

endpackage

// File: rtl/mem_lane_ext.sv
// Selects the addressed byte/half/word lane of a memory read word and sign- or
// zero-extends it to the full data path width.
module mem_lane_ext
   import mem_align_unit_pkg::*;
#(
   parameter int DATA_W = 32
) (
   input  logic [DATA_W-1:0]            rdata,
   input  logic [$clog2(DATA_W/8)-1:0]  ofs,
   input  size_e                        size,
   input  logic                         sign,
   output logic [DATA_W-1:0]            result
);

   logic [7:0]  lane_b;
   logic [15:0] lane_h;
   logic [31:0] lane_w;

   always_comb begin
      lane_b = 8'(rdata >> {ofs, 3'b000});
      lane_h = 16'(rdata >> {ofs, 3'b000});
      lane_w = 32'(rdata >> {ofs, 3'b000});
      case (size)
         SZ_BYTE: result = sign ? DATA_W'($signed(lane_b)) : DATA_W'(lane_b);
         SZ_HALF: result = sign ? DATA_W'($signed(lane_h)) : DATA_W'(lane_h);
         default: result = sign ? DATA_W'($signed(lane_w)) : DATA_W'(lane_w);
      endcase
   end

endmodule

// File: rtl/mem_align_unit.sv
// M-stage load/store alignment unit: lane enables, store replication, load extension.
// Define MEM_ALIGN_EXC_EN to trap misaligned half/word accesses (adel/ades/badvaddr).
module mem_align_unit
   import mem_align_unit_pkg::*;
#(
   parameter int DATA_W = 32,
   parameter int OP_W   = 8
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                req_valid,
   output logic                req_ready,
   input  logic [OP_W-1:0]     req_op,
   input  logic [31:0]         req_addr,
   input  logic [DATA_W-1:0]   req_wdata,
   input  logic                flush,
   output logic                dmem_req,
   output logic [DATA_W/8-1:0] dmem_we,
   output logic [31:0]         dmem_addr,
   output logic [DATA_W-1:0]   dmem_wdata,
   input  logic [DATA_W-1:0]   dmem_rdata,
   input  logic                dmem_ack,
   output logic                resp_valid,
   output logic [DATA_W-1:0]   resp_data,
   output logic                stall,
   output logic                adel,
   output logic                ades,
   output logic [31:0]         badvaddr
);

   localparam int BL    = DATA_W / 8;
   localparam int OFS_W = $clog2(BL);

   logic [1:0]        state_q, state_d;
   logic              kill_q, kill_d;
   op_info_t          info, info_q;
   logic [OFS_W-1:0]  ofs, ofs_q;
   logic [31:0]       addr_q;
   logic [DATA_W-1:0] wdata_rep, wdata_q;
   logic [BL-1:0]     lane_mask, we_q;
   logic [DATA_W-1:0] ext_data, rdata_q;
   logic              take, accept;

   assign info      = decode_op(8'(req_op));
   assign req_ready = (state_q != ST_WAIT);
   assign take      = req_valid & req_ready & ~flush & info.valid;

`ifdef MEM_ALIGN_EXC_EN
   logic        misaligned;
   logic        adel_q, ades_q;
   logic [31:0] badvaddr_q;

   assign misaligned = ((info.size == SZ_HALF) && req_addr[0]) ||
                       ((info.size == SZ_WORD) && (req_addr[1:0] != 2'b00));
   assign accept     = take & ~misaligned;
   assign ofs        = req_addr[OFS_W-1:0];

   // Rejected accesses report for one cycle and never reach the memory.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         adel_q     <= 1'b0;
         ades_q     <= 1'b0;
         badvaddr_q <= '0;
      end else begin
         adel_q     <= take & misaligned & ~info.store;
         ades_q     <= take & misaligned & info.store;
         badvaddr_q <= (take & misaligned) ? req_addr : '0;
      end
   end

   assign adel     = adel_q;
   assign ades     = ades_q;
   assign badvaddr = badvaddr_q;
`else
   logic [OFS_W-1:0] ofs_keep;

   // Misaligned offsets are rounded down to the access size's natural alignment.
   always_comb begin
      case (info.size)
         SZ_HALF: ofs_keep = ~OFS_W'(1);
         SZ_WORD: ofs_keep = ~OFS_W'(3);
         default: ofs_keep = '1;
      endcase
   end

   assign accept   = take;
   assign ofs      = req_addr[OFS_W-1:0] & ofs_keep;
   assign adel     = 1'b0;
   assign ades     = 1'b0;
   assign badvaddr = '0;
`endif

   always_comb begin
      case (info.size)
         SZ_BYTE: begin
            lane_mask = BL'(LANE_MASK_B);
            wdata_rep = {BL{req_wdata[7:0]}};
         end
         SZ_HALF: begin
            lane_mask = BL'(LANE_MASK_H);
            wdata_rep = {(BL/2){req_wdata[15:0]}};
         end
         default: begin
            lane_mask = BL'(LANE_MASK_W);
            wdata_rep = {(BL/4){req_wdata[31:0]}};
         end
      endcase
   end

   always_comb begin
      state_d = state_q;
      kill_d  = kill_q;
      case (state_q)
         ST_IDLE: begin
            if (accept) begin
               state_d = ST_WAIT;
               kill_d  = 1'b0;
            end
         end
         ST_WAIT: begin
            if (flush) kill_d = 1'b1;
            if (dmem_ack) state_d = ST_RESP;
         end
         ST_RESP: begin
            if (accept) begin
               state_d = ST_WAIT;
               kill_d  = 1'b0;
            end else begin
               state_d = ST_IDLE;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   mem_lane_ext #(
      .DATA_W (DATA_W)
   ) u_lane_ext (
      .rdata  (dmem_rdata),
      .ofs    (ofs_q),
      .size   (info_q.size),
      .sign   (info_q.sign),
      .result (ext_data)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= ST_IDLE;
         kill_q  <= 1'b0;
         info_q  <= '0;
         ofs_q   <= '0;
         addr_q  <= '0;
         wdata_q <= '0;
         we_q    <= '0;
         rdata_q <= '0;
      end else begin
         state_q <= state_d;
         kill_q  <= kill_d;
         if (accept) begin
            info_q  <= info;
            ofs_q   <= ofs;
            addr_q  <= {req_addr[31:OFS_W], {OFS_W{1'b0}}};
            wdata_q <= wdata_rep;
            we_q    <= info.store ? (lane_mask << ofs) : '0;
         end
         if ((state_q == ST_WAIT) && dmem_ack) begin
            rdata_q <= info_q.store ? '0 : ext_data;
         end
      end
   end

   assign dmem_req   = (state_q == ST_WAIT);
   assign dmem_we    = dmem_req ? we_q : '0;
   assign dmem_addr  = dmem_req ? addr_q : '0;
   assign dmem_wdata = dmem_req ? wdata_q : '0;
   assign resp_valid = (state_q == ST_RESP) & ~kill_q;
   assign resp_data  = resp_valid ? rdata_q : '0;
   assign stall      = (state_q == ST_WAIT) | (req_valid & ~req_ready);

endmodule
